// File: rtl/banco_banda.sv
// -----------------------------------------------------------------------------
// banco_banda
//   Multi-channel, double-buffered sample bank for the FILTRO path.
//   Producers capture one sample at a time into a per-channel shadow register.
//   A single commit strobe moves every pending shadow into the newest tap of
//   that channel's history line, shifting older taps down (oldest dropped).
//   One registered read port returns any channel/tap with one clock latency.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (clears all state)
//   in           sample to capture
//   canal_in     target channel for capture
//   leer         capture strobe: shadow[canal_in] <= in
//   escribir     commit strobe: pending shadows shift into history
//   rd_en        read request
//   rd_canal     read channel
//   rd_tap       read tap (0 = newest)
//   out          registered read data
//   out_valido   one-cycle pulse, out updated this cycle
//   pendiente    per-channel "shadow holds an uncommitted sample" flags
//   err_sobre    sticky: pending shadow overwritten before commit
//   err_idx      sticky: out-of-range channel or tap used
//   limpiar_err  clears both sticky flags (a same-cycle new error wins)
// -----------------------------------------------------------------------------
module banco_banda #(
    parameter int ANCHO   = 25,
    parameter int CANALES = 4,
    parameter int PROF    = 3,
    parameter int CW      = (CANALES > 1) ? $clog2(CANALES) : 1,
    parameter int TW      = (PROF > 1) ? $clog2(PROF) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ANCHO-1:0]   in,
    input  logic [CW-1:0]      canal_in,
    input  logic               leer,
    input  logic               escribir,
    input  logic               rd_en,
    input  logic [CW-1:0]      rd_canal,
    input  logic [TW-1:0]      rd_tap,
    output logic [ANCHO-1:0]   out,
    output logic               out_valido,
    output logic [CANALES-1:0] pendiente,
    output logic               err_sobre,
    output logic               err_idx,
    input  logic               limpiar_err
);

    logic [ANCHO-1:0] shadow [CANALES];
    logic [ANCHO-1:0] hist   [CANALES][PROF];

    logic             cap_rango;
    logic             cap_ok;
    logic             rd_ok;
    logic             sobre_evt;
    logic             idx_evt;
    logic [CANALES-1:0] pend_nxt;

    // Index range checks; only meaningful when CANALES/PROF are not powers of 2.
    assign cap_rango = (32'(canal_in) < CANALES);
    assign cap_ok    = leer && cap_rango;
    assign rd_ok     = (32'(rd_canal) < CANALES) && (32'(rd_tap) < PROF);

    // Overwrite is only an error when no commit drains the old value this cycle.
    assign sobre_evt = cap_ok && pendiente[canal_in] && !escribir;
    assign idx_evt   = (leer && !cap_rango) || (rd_en && !rd_ok);

    // A commit clears every pending flag (non-pending ones are already 0);
    // a simultaneous capture re-arms its channel for the next commit.
    always_comb begin
        pend_nxt = escribir ? '0 : pendiente;
        if (cap_ok) begin
            pend_nxt[canal_in] = 1'b1;
        end
    end

    // ---- capture / commit stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CANALES; c++) begin
                shadow[c] <= '0;
                for (int k = 0; k < PROF; k++) begin
                    hist[c][k] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < CANALES; c++) begin
                if (escribir && pendiente[c]) begin
                    for (int k = PROF - 1; k > 0; k--) begin
                        hist[c][k] <= hist[c][k-1];
                    end
                    hist[c][0] <= shadow[c];
                end
            end
            // Commit above reads the pre-edge shadow, so a same-cycle capture
            // is held back for the following commit.
            if (cap_ok) begin
                shadow[canal_in] <= in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendiente <= '0;
            err_sobre <= 1'b0;
            err_idx   <= 1'b0;
        end else begin
            pendiente <= pend_nxt;
            err_sobre <= sobre_evt | (err_sobre & ~limpiar_err);
            err_idx   <= idx_evt   | (err_idx   & ~limpiar_err);
        end
    end

    // ---- read stage (one clock, sees pre-commit history) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out        <= '0;
            out_valido <= 1'b0;
        end else begin
            out_valido <= rd_en;
            if (rd_en) begin
                out <= rd_ok ? hist[rd_canal][rd_tap] : '0;
            end
        end
    end

endmodule

// File: tb/tb_banco_banda.sv
module tb_banco_banda;
    localparam int ANCHO   = 25;
    localparam int CANALES = 4;
    localparam int PROF    = 3;
    localparam int CW      = 2;
    localparam int TW      = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [ANCHO-1:0]   in = '0;
    logic [CW-1:0]      canal_in = '0;
    logic               leer = 1'b0;
    logic               escribir = 1'b0;
    logic               rd_en = 1'b0;
    logic [CW-1:0]      rd_canal = '0;
    logic [TW-1:0]      rd_tap = '0;
    logic [ANCHO-1:0]   out;
    logic               out_valido;
    logic [CANALES-1:0] pendiente;
    logic               err_sobre;
    logic               err_idx;
    logic               limpiar_err = 1'b0;

    int checks = 0;
    int errors = 0;

    banco_banda #(.ANCHO(ANCHO), .CANALES(CANALES), .PROF(PROF)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .canal_in(canal_in),
        .leer(leer), .escribir(escribir), .rd_en(rd_en),
        .rd_canal(rd_canal), .rd_tap(rd_tap), .out(out),
        .out_valido(out_valido), .pendiente(pendiente),
        .err_sobre(err_sobre), .err_idx(err_idx), .limpiar_err(limpiar_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // History kept as a newest-first queue per channel.
    logic [ANCHO-1:0]   m_sh   [CANALES];
    logic [ANCHO-1:0]   m_hist [CANALES][$];
    logic [CANALES-1:0] m_pend;
    logic [ANCHO-1:0]   m_out;
    logic               m_vld, m_sobre, m_idx;

    task automatic model_reset();
        for (int c = 0; c < CANALES; c++) begin
            m_sh[c] = '0;
            m_hist[c].delete();
            for (int k = 0; k < PROF; k++) m_hist[c].push_back('0);
        end
        m_pend = '0; m_out = '0; m_vld = 0; m_sobre = 0; m_idx = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic cap_in_range, rd_in_range, set_sobre, set_idx;
            logic [CANALES-1:0] old_pend;
            cap_in_range = int'(canal_in) < CANALES;
            rd_in_range  = (int'(rd_canal) < CANALES) && (int'(rd_tap) < PROF);
            old_pend = m_pend;
            // read uses pre-commit history
            m_vld = rd_en;
            if (rd_en) m_out = rd_in_range ? m_hist[rd_canal][rd_tap] : '0;
            set_sobre = leer && cap_in_range && old_pend[canal_in] && !escribir;
            set_idx   = (leer && !cap_in_range) || (rd_en && !rd_in_range);
            m_sobre = set_sobre || (m_sobre && !limpiar_err);
            m_idx   = set_idx   || (m_idx   && !limpiar_err);
            if (escribir) begin
                for (int c = 0; c < CANALES; c++) begin
                    if (old_pend[c]) begin
                        m_hist[c].push_front(m_sh[c]);
                        void'(m_hist[c].pop_back());
                    end
                end
                m_pend = '0;
            end
            if (leer && cap_in_range) begin
                m_sh[canal_in] = in;
                m_pend[canal_in] = 1'b1;
            end
        end
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("out_valido", 32'(out_valido), 32'(m_vld));
        chk("pendiente", 32'(pendiente), 32'(m_pend));
        chk("err_sobre", 32'(err_sobre), 32'(m_sobre));
        chk("err_idx", 32'(err_idx), 32'(m_idx));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic l, input int ci, input int din, input logic e,
                         input logic r, input int rc, input int rt, input logic clr);
        @(negedge clk);
        leer = l; canal_in = CW'(ci); in = ANCHO'(din); escribir = e;
        rd_en = r; rd_canal = CW'(rc); rd_tap = TW'(rt); limpiar_err = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cap(input int ch, input int v);
        drive(1, ch, v, 0, 0, 0, 0, 0);
    endtask

    task automatic commit();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Read then land on the next negedge, where out is already updated.
    task automatic rd_expect(input string name, input int ch, input int tap, input int exp);
        drive(0, 0, 0, 0, 1, ch, tap, 0);
        idle();
        chk(name, 32'(out), 32'(exp));
        chk({name, "_model"}, 32'(m_out), 32'(exp));
        chk({name, "_vld"}, 32'(out_valido), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        rd_expect("rst_ch0t0", 0, 0, 0);
        chk("rst_err_sobre", 32'(err_sobre), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);
        chk("valid_pulse", 32'(out_valido), 32'd1);
        idle();
        chk("valid_drops", 32'(out_valido), 32'd0);

        // single capture/commit on ch1
        cap(1, 'h0ABCDE);
        idle();
        chk("pend_0010", 32'(pendiente), 32'b0010);
        commit();
        idle();
        chk("pend_0000", 32'(pendiente), 32'b0000);
        rd_expect("ch1t0", 1, 0, 'h0ABCDE);
        rd_expect("ch0t0", 0, 0, 0);

        // history shift on ch2
        for (int v = 1; v <= 3; v++) begin cap(2, v); commit(); end
        rd_expect("ch2t0_r3", 2, 0, 3);
        rd_expect("ch2t1_r3", 2, 1, 2);
        rd_expect("ch2t2_r3", 2, 2, 1);
        cap(2, 4); commit();
        rd_expect("ch2t0_r4", 2, 0, 4);
        rd_expect("ch2t1_r4", 2, 1, 3);
        rd_expect("ch2t2_r4", 2, 2, 2);
        rd_expect("ch1t1_untouched", 1, 1, 0);

        // overwrite before commit
        cap(3, 5); cap(3, 6);
        idle();
        chk("err_sobre_set", 32'(err_sobre), 32'd1);
        commit();
        rd_expect("ch3t0_ovw", 3, 0, 6);
        rd_expect("ch3t1_ovw", 3, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("err_sobre_clr", 32'(err_sobre), 32'd0);

        // simultaneous capture and commit
        cap(0, 9);
        drive(1, 0, 7, 1, 0, 0, 0, 0);
        idle();
        chk("pend0_rearm", 32'(pendiente), 32'b0001);
        chk("no_sobre_simul", 32'(err_sobre), 32'd0);
        rd_expect("ch0t0_simul", 0, 0, 9);
        commit();
        rd_expect("ch0t0_next", 0, 0, 7);
        rd_expect("ch0t1_next", 0, 1, 9);

        // read during commit returns pre-commit value
        cap(0, 'h1FFFFFF);
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        idle();
        chk("rd_precommit", 32'(out), 32'd7);
        rd_expect("ch0t0_full", 0, 0, 'h1FFFFFF);

        // out-of-range tap
        rd_expect("tap3_zero", 0, 3, 0);
        chk("err_idx_set", 32'(err_idx), 32'd1);
        drive(0, 0, 0, 0, 1, 0, 3, 1);   // clear with new error: set wins
        idle();
        chk("err_idx_setwins", 32'(err_idx), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("err_idx_clr", 32'(err_idx), 32'd0);

        // rd_en low holds out
        drive(0, 0, 0, 0, 1, 2, 0, 0);
        idle(); idle();
        chk("out_hold", 32'(out), 32'd4);

        // asynchronous reset mid-pending
        cap(1, 'h155);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pend", 32'(pendiente), 32'd0);
        chk("arst_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        commit();
        rd_expect("arst_ch1t0", 1, 0, 0);
        rd_expect("arst_ch2t0", 2, 0, 0);
        rd_expect("arst_ch0t1", 0, 1, 0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/banco_banda.md
Name: banco_banda

Overview:
- Parametrised successor to the filter band register: a multi-channel, double-buffered sample bank with per-channel history (delay taps) for the FILTRO path.
- Producers capture samples per channel into shadow registers.
- A single commit strobe atomically shifts all pending samples into each channel's history line.
- Filter arithmetic reads any channel/tap through one registered read port.

Parameters:
- ANCHO, 25, sample width in bits.
- CANALES, 4, number of band channels (≥1).
- PROF, 3, history depth per channel (taps 0..PROF-1, tap 0 = newest).
- CW, $clog2(CANALES) (min 1), channel index width.
- TW, $clog2(PROF) (min 1), tap index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  ANCHO  sample to capture.
- canal_in  in  CW  target channel for capture.
- leer  in  1  capture strobe; loads in into shadow[canal_in].
- escribir  in  1  commit strobe; shifts all pending shadows into history.
- rd_en  in  1  read request.
- rd_canal  in  CW  read channel.
- rd_tap  in  TW  read tap.
- out  out  ANCHO  read data, registered.
- out_valido  out  1  one-cycle pulse; out updated this cycle.
- pendiente  out  CANALES  per-channel shadow-holds-uncommitted-sample flags.
- err_sobre  out  1  sticky; a pending shadow was overwritten before commit.
- err_idx  out  1  sticky; out-of-range channel or tap used.
- limpiar_err  in  1  clears both sticky error flags.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all shadow and history registers are 0; pendiente=0; out=0.
  - out_valido=0; err_sobre=0; err_idx=0.
  - Reset mid-operation discards pending samples; no commit occurs.
- Capture (leer=1, canal_in<CANALES):
  - shadow[canal_in] <= in; pendiente[canal_in] <= 1 at the same edge.
  - If pendiente[canal_in] was already 1 and escribir=0 that cycle: new value replaces old and err_sobre <= 1.
- Capture with canal_in≥CANALES: no register written; err_idx <= 1.
- Commit (escribir=1): for every channel c with pendiente[c]=1 before the edge:
  - hist[c][k] <= hist[c][k-1] for k=PROF-1..1.
  - hist[c][0] <= shadow[c].
  - pendiente[c] <= 0.
  - Non-pending channels keep their history untouched.
  - escribir with no pending channels: no state change.
- Simultaneous leer and escribir:
  - Commit uses the shadow contents from before the edge.
  - The captured sample lands in shadow and leaves pendiente[canal_in]=1 for the next commit.
  - No err_sobre in this case. Leer has no priority over escribir: both act.
- Read (rd_en=1):
  - At the next edge, out <= hist[rd_canal][rd_tap] and out_valido <= 1 for exactly one cycle.
  - Latency is 1 clock.
  - A read in the same cycle as a commit returns the pre-commit value.
  - rd_en=0: out holds its last value; out_valido=0.
  - rd_canal≥CANALES or rd_tap≥PROF: out <= 0, out_valido <= 1, err_idx <= 1.
- Error flags: limpiar_err clears both at the next edge. If a new error event occurs in the same cycle, set wins.
- Arithmetic: none. Values pass unmodified at full ANCHO width; no sign handling.
- PROF=1 degenerates to one register per channel (commit overwrites tap 0).

Test Plan:
- Reset then read ch0 tap0 → out=0, out_valido=1 one cycle after rd_en, err flags 0.
- leer ch1 in=0x0ABCDE; escribir; read ch1 tap0 → 0x0ABCDE. Read ch0 tap0 → 0, ch0 history unchanged. pendiente goes 0010→0000.
- Three capture/commit rounds on ch2 with 1,2,3 → taps 0/1/2 read 3/2/1. Fourth round with 4 → 4/3/2 (oldest dropped).
- leer ch3=5, leer ch3=6, escribir → err_sobre=1, tap0=6. limpiar_err → err_sobre=0.
- leer ch0=7 with escribir in same cycle while ch0 pending=9 → tap0=9, pendiente[0]=1. Next escribir → tap0=7, tap1=9.
- Read rd_tap=3 with PROF=3 → out=0, err_idx=1. Assert rst_n low mid-pending → pendiente=0, all taps 0.
